// File: rtl/sum_uart_tx.sv
// sum_uart_tx: sends each accepted adder sum as a UART frame of start bit,
// 8 data bits LSB first, optional even parity bit, and 1 or 2 stop bits.
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end    = cnt_q == CNT_LAST;
    assign sum_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign tx         = tx_q;
    assign frame_done = done_q;

    // tx_d always carries the level for the next bit so tx stays registered
    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (sum_valid) begin
                    state_d   = START;
                    shift_d   = sum_in;
                    par_d     = ^sum_in;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                    if (bit_idx_q == 3'd7) begin
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                        tx_d      = (PARITY_EN != 0) ? par_q : 1'b1;
                        bit_idx_d = '0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: three transmitter configurations; stimulus queues expected
// bytes, a per-lane UART receiver monitor decodes frames and checks them.
module tb_sum_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sin [3];
    logic       sv [3];
    logic       sr [3];
    logic       txw [3];
    logic       bzw [3];
    logic       fdw [3];
    // entry: {back_to_back_next, expected_parity, byte}
    logic [9:0] q [3][$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int C  = (g == 2) ? 1 : 4;
        localparam int P  = (g == 0) ? 1 : 0;
        localparam int S  = (g == 2) ? 2 : 1;
        localparam int NB = 9 + P + S;
        localparam int L  = NB * C;

        sum_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(P), .STOP_BITS(S)) dut (
            .clk(clk), .rst_n(rst_n), .sum_in(sin[g]), .sum_valid(sv[g]),
            .sum_ready(sr[g]), .tx(txw[g]), .busy(bzw[g]), .frame_done(fdw[g])
        );

        task automatic step(inout bit ab);
            @(posedge clk);
            #1;
            if (!rst_n) ab = 1'b1;
        endtask

        initial begin : mon
            int         n;
            bit         ab;
            bit         allbusy;
            logic [11:0] fr;
            logic [9:0] e;
            ab = 1'b0;
            e  = '0;
            step(ab);
            forever begin
                if (!(rst_n && bzw[g] && !txw[g])) begin
                    step(ab);
                    continue;
                end
                n = 0;
                ab = 1'b0;
                fr = '1;
                allbusy = 1'b1;
                for (int k = 0; k < NB && !ab; k++) begin
                    while (n < k * C + C / 2 && !ab) begin
                        step(ab);
                        n++;
                        allbusy &= bzw[g];
                    end
                    fr[k] = txw[g];
                end
                while (!fdw[g] && n <= L && !ab) begin
                    step(ab);
                    n++;
                    if (!fdw[g]) allbusy &= bzw[g];
                end
                if (ab) continue;
                chk($sformatf("lane%0d frame_len", g), 32'(n), 32'(L));
                chk($sformatf("lane%0d busy_in_frame", g), 32'(allbusy), 1);
                chk($sformatf("lane%0d busy_ready_at_done", g), 32'({bzw[g], sr[g]}), 1);
                chk($sformatf("lane%0d start_bit", g), 32'(fr[0]), 0);
                chk($sformatf("lane%0d stop_bits", g), 32'(fr[NB-1 -: S]), (1 << S) - 1);
                chk($sformatf("lane%0d expected_frame", g), 32'(q[g].size() != 0), 1);
                if (q[g].size() != 0) begin
                    e = q[g].pop_front();
                    chk($sformatf("lane%0d data", g), 32'(fr[8:1]), 32'(e[7:0]));
                    chk($sformatf("lane%0d bit9", g), 32'(fr[9]), 32'((P != 0) ? e[8] : 1'b1));
                end
                step(ab);
                chk($sformatf("lane%0d done_one_cycle", g), 32'(fdw[g]), 0);
                if (e[9]) chk($sformatf("lane%0d b2b_start", g), 32'(txw[g]), 0);
            end
        end
    end

    task automatic send(input int g, input logic [7:0] b, input logic [9:0] e,
                        input bit hold, input bit push);
        int t;
        t = 0;
        if (push) q[g].push_back(e);
        @(negedge clk);
        sin[g] = b;
        sv[g]  = 1'b1;
        while (!sr[g] && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("lane%0d accept", g), 32'(t < 400), 1);
        @(posedge clk);
        #1;
        sv[g]  = hold;
        sin[g] = ~b;
    endtask

    initial begin
        logic [7:0] ui, uio;
        int t;
        for (int g = 0; g < 3; g++) begin
            sv[g]  = 1'b0;
            sin[g] = '0;
        end
        #12;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("lane%0d reset_tx", g), 32'(txw[g]), 1);
            chk($sformatf("lane%0d reset_busy", g), 32'(bzw[g]), 0);
            chk($sformatf("lane%0d reset_ready", g), 32'(sr[g]), 1);
            chk($sformatf("lane%0d reset_done", g), 32'(fdw[g]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send(0, 8'hA5, {2'b00, 8'hA5}, 1'b0, 1'b1);
        send(0, 8'h07, {2'b01, 8'h07}, 1'b0, 1'b1);
        ui  = 8'hF0;
        uio = 8'h20;
        send(0, ui + uio, {2'b01, 8'h10}, 1'b0, 1'b1);
        send(0, 8'h55, {2'b10, 8'h55}, 1'b1, 1'b1);
        send(0, 8'hAA, {2'b00, 8'hAA}, 1'b0, 1'b1);

        send(0, 8'hC3, 10'h0, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        chk("midframe_bit3_tx", 32'(txw[0]), 0);
        chk("midframe_busy", 32'(bzw[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", 32'(txw[0]), 1);
        chk("async_reset_busy", 32'(bzw[0]), 0);
        chk("async_reset_ready", 32'(sr[0]), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(0, 8'h3C, {2'b00, 8'h3C}, 1'b0, 1'b1);

        send(1, 8'h07, {2'b01, 8'h07}, 1'b0, 1'b1);
        send(2, 8'hFF, {2'b10, 8'hFF}, 1'b1, 1'b1);
        send(2, 8'h81, {2'b00, 8'h81}, 1'b0, 1'b1);

        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(t < 3000), 1);
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
